// File: rtl/sram_wb_arbiter.sv
// Two-master Wishbone arbiter/sequencer in front of the secure SRAM wrapper.
// Round-robin between mgmt bus (m0) and crypto/UART engine (m1).
// Optional key-erasure sweep is compiled in with SRAM_ARB_ZEROIZE_EN.
// Ports: wb_clk_i, rst_n (async low); m0_*/m1_* Wishbone masters;
// s_* Wishbone toward the wrapper; zeroize_i/_busy_o/_done_o sweep control.
module sram_wb_arbiter #(
  parameter int unsigned ADDR_WD = 9,
  parameter int unsigned DATA_WD = 32,
  parameter logic [ADDR_WD-1:0] ZERO_ADDR_LAST = 9'h1FF
) (
  input  logic                 wb_clk_i,
  input  logic                 rst_n,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_we_i,
  input  logic [ADDR_WD-1:0]   m0_adr_i,
  input  logic [DATA_WD-1:0]   m0_dat_i,
  input  logic [DATA_WD/8-1:0] m0_sel_i,
  output logic [DATA_WD-1:0]   m0_dat_o,
  output logic                 m0_ack_o,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  input  logic [ADDR_WD-1:0]   m1_adr_i,
  input  logic [DATA_WD-1:0]   m1_dat_i,
  input  logic [DATA_WD/8-1:0] m1_sel_i,
  output logic [DATA_WD-1:0]   m1_dat_o,
  output logic                 m1_ack_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [ADDR_WD-1:0]   s_adr_o,
  output logic [DATA_WD-1:0]   s_dat_o,
  output logic [DATA_WD/8-1:0] s_sel_o,
  input  logic [DATA_WD-1:0]   s_dat_i,
  input  logic                 s_ack_i,
  input  logic                 zeroize_i,
  output logic                 zeroize_busy_o,
  output logic                 zeroize_done_o
);

`ifdef SRAM_ARB_ZEROIZE_EN
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, ZERO} state_e;
`else
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_e;
`endif

  state_e state_q;
  logic   last_q;
  logic   req0, req1;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

`ifdef SRAM_ARB_ZEROIZE_EN
  logic [ADDR_WD-1:0] zaddr_q;
  logic               done_q;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      zaddr_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (zeroize_i) begin
            state_q <= ZERO;
            zaddr_q <= '0;
          end else if (req0 && (!req1 || last_q)) begin
            state_q <= BUSY0;
            last_q  <= 1'b0;
          end else if (req1) begin
            state_q <= BUSY1;
            last_q  <= 1'b1;
          end
        end
        BUSY0, BUSY1: begin
          if (s_ack_i) state_q <= IDLE;
        end
        ZERO: begin
          if (s_ack_i) begin
            if (zaddr_q == ZERO_ADDR_LAST) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              zaddr_q <= zaddr_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign zeroize_busy_o = (state_q == ZERO);
  assign zeroize_done_o = done_q;
`else
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0 && (!req1 || last_q)) begin
            state_q <= BUSY0;
            last_q  <= 1'b0;
          end else if (req1) begin
            state_q <= BUSY1;
            last_q  <= 1'b1;
          end
        end
        BUSY0, BUSY1: begin
          if (s_ack_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic unused_zero;
  assign unused_zero    = zeroize_i ^ (^ZERO_ADDR_LAST);
  assign zeroize_busy_o = 1'b0;
  assign zeroize_done_o = 1'b0;
`endif

  // Read data goes to both masters; only the acked one consumes it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // The wrapper ack is registered, so the ack -> stb/ack paths are short.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    unique case (state_q)
      BUSY0: begin
        s_cyc_o  = 1'b1;
        s_stb_o  = !s_ack_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i;
      end
      BUSY1: begin
        s_cyc_o  = 1'b1;
        s_stb_o  = !s_ack_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
      end
`ifdef SRAM_ARB_ZEROIZE_EN
      ZERO: begin
        s_cyc_o = 1'b1;
        s_stb_o = !s_ack_i;
        s_we_o  = 1'b1;
        s_adr_o = zaddr_q;
        s_sel_o = '1;
      end
`endif
      default: ;
    endcase
  end

endmodule
